// File: rtl/column_double_buffer.sv
// Two-bank column store: writer fills the back bank, GPU scans the front.
// Bank exchange commits only on a v_sync falling edge.
module column_double_buffer #(
   parameter int COLS   = 320,
   parameter int IDX_W  = 9,
   parameter int TEX_W  = 6,
   parameter int DIST_W = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic [TEX_W-1:0]  wr_texture,
   input  logic [DIST_W-1:0] wr_distance,
   input  logic              fill_req,
   input  logic              swap_req,
   input  logic              v_sync,
   input  logic [IDX_W-1:0]  reading_index,
   output logic [15:0]       texture,
   output logic [DIST_W-1:0] distance,
   output logic              reading_buffer,
   output logic              swap_pending,
   output logic              wr_error
);

   localparam int W = TEX_W + DIST_W;
   localparam logic [IDX_W-1:0] LIMIT = IDX_W'(COLS);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(COLS - 1);

   typedef enum logic [1:0] {IDLE, FILL, WAIT_VS} state_t;

   state_t           state, state_n;
   logic [IDX_W-1:0] cnt, cnt_n;
   logic             pend_n, rb_n, err_n;
   logic             prev_vs, vsync_fall;
   logic             acc, in_range, we;
   logic [IDX_W-1:0] waddr;
   logic [W-1:0]     wdata, rd;

   logic [W-1:0] bank0 [COLS];
   logic [W-1:0] bank1 [COLS];

   assign wr_ready   = (state == IDLE);
   assign vsync_fall = prev_vs & ~v_sync;
   assign acc        = wr_valid & wr_ready;
   assign in_range   = (wr_index < LIMIT);

   // Fill and host writes never overlap: writes only land in IDLE.
   assign we    = (acc & in_range) | (state == FILL);
   assign waddr = (state == FILL) ? cnt : wr_index;
   assign wdata = (state == FILL) ? '0 : {wr_texture, wr_distance};

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pend_n  = swap_pending;
      rb_n    = reading_buffer;
      err_n   = wr_error | (acc & ~in_range);
      unique case (state)
         IDLE: begin
            if (fill_req) begin
               state_n = FILL;
               cnt_n   = '0;
               pend_n  = swap_pending | swap_req;
            end else if (swap_req) begin
               state_n = WAIT_VS;
               pend_n  = 1'b1;
            end
         end
         FILL: begin
            pend_n = swap_pending | swap_req;
            if (cnt == LAST)
               state_n = pend_n ? WAIT_VS : IDLE;
            else
               cnt_n = cnt + 1'b1;
         end
         WAIT_VS: begin
            if (vsync_fall) begin
               rb_n    = ~reading_buffer;
               pend_n  = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state          <= IDLE;
         cnt            <= '0;
         swap_pending   <= 1'b0;
         reading_buffer <= 1'b0;
         wr_error       <= 1'b0;
         prev_vs        <= 1'b1;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         swap_pending   <= pend_n;
         reading_buffer <= rb_n;
         wr_error       <= err_n;
         prev_vs        <= v_sync;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr && we && reading_buffer)
         bank0[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (!clr && we && !reading_buffer)
         bank1[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (clr)
         rd <= '0;
      else if (reading_index < LIMIT)
         rd <= reading_buffer ? bank1[reading_index] : bank0[reading_index];
      else
         rd <= '0;
   end

   assign texture  = {{(16 - TEX_W){1'b0}}, rd[W-1:DIST_W]};
   assign distance = rd[DIST_W-1:0];

endmodule

// File: tb/tb_column_double_buffer.sv
// Scoreboard bench for column_double_buffer: bench-side bank model,
// read expectations queued at address time and popped one cycle later.
module tb_column_double_buffer;

   localparam int COLS = 320;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [8:0]  wr_index = '0;
   logic [5:0]  wr_texture = '0;
   logic [15:0] wr_distance = '0;
   logic        fill_req = 1'b0;
   logic        swap_req = 1'b0;
   logic        v_sync = 1'b1;
   logic [8:0]  reading_index = '0;
   logic [15:0] texture;
   logic [15:0] distance;
   logic        reading_buffer;
   logic        swap_pending;
   logic        wr_error;

   int errors = 0;
   int checks = 0;

   logic [5:0]  m_tex  [2][COLS];
   logic [15:0] m_dist [2][COLS];
   logic        m_rb = 1'b0;
   logic [31:0] exp_q [$];

   column_double_buffer dut (
      .clk(clk), .clr(clr),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_index(wr_index), .wr_texture(wr_texture),
      .wr_distance(wr_distance),
      .fill_req(fill_req), .swap_req(swap_req), .v_sync(v_sync),
      .reading_index(reading_index),
      .texture(texture), .distance(distance),
      .reading_buffer(reading_buffer),
      .swap_pending(swap_pending), .wr_error(wr_error)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: no finish, actual=timeout required=done");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pop_cmp();
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({texture, distance} !== e) begin
         errors++;
         $display("FAIL read: actual tex=%0h dist=%0h required tex=%0h dist=%0h",
                  texture, distance, e[31:16], e[15:0]);
      end
   endtask

   task automatic read_seq(input int lo, input int hi, input int step);
      for (int i = lo; i <= hi; i += step) begin
         if (exp_q.size() > 0) pop_cmp();
         reading_index = 9'(i);
         if (i < COLS)
            exp_q.push_back({10'b0, m_tex[m_rb][i], m_dist[m_rb][i]});
         else
            exp_q.push_back(32'h0);
         @(negedge clk);
      end
      if (exp_q.size() > 0) pop_cmp();
   endtask

   task automatic do_write(input int idx, input logic [5:0] t,
                           input logic [15:0] d);
      wr_valid = 1'b1;
      wr_index = 9'(idx);
      wr_texture = t;
      wr_distance = d;
      if (wr_ready && idx < COLS) begin
         m_tex[~m_rb][idx] = t;
         m_dist[~m_rb][idx] = d;
      end
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic pulse_swap();
      swap_req = 1'b1;
      @(negedge clk);
      swap_req = 1'b0;
   endtask

   task automatic vsync_fall();
      v_sync = 1'b0;
      @(negedge clk);
      v_sync = 1'b1;
   endtask

   task automatic model_fill();
      for (int i = 0; i < COLS; i++) begin
         m_tex[~m_rb][i] = '0;
         m_dist[~m_rb][i] = '0;
      end
   endtask

   task automatic test_reset();
      clr = 1'b1;
      cycles(2);
      clr = 1'b0;
      m_rb = 1'b0;
      chk("rst_wr_ready", 32'(wr_ready), 1);
      chk("rst_reading_buffer", 32'(reading_buffer), 0);
      chk("rst_swap_pending", 32'(swap_pending), 0);
      chk("rst_wr_error", 32'(wr_error), 0);
      chk("rst_texture", 32'(texture), 0);
      chk("rst_distance", 32'(distance), 0);
   endtask

   task automatic test_write_swap();
      do_write(5, 6'h2A, 16'h1234);
      do_write(7, 6'h11, 16'h7777);
      pulse_swap();
      chk("ws_pending", 32'(swap_pending), 1);
      chk("ws_ready_low", 32'(wr_ready), 0);
      cycles(5);
      chk("ws_no_early_swap", 32'(reading_buffer), 0);
      do_write(7, 6'h3F, 16'hFFFF);
      chk("ws_blocked_write_ready", 32'(wr_ready), 0);
      chk("ws_pending_hold", 32'(swap_pending), 1);
      vsync_fall();
      m_rb = ~m_rb;
      chk("ws_rb_toggled", 32'(reading_buffer), 1);
      chk("ws_pending_clear", 32'(swap_pending), 0);
      chk("ws_ready_back", 32'(wr_ready), 1);
      read_seq(5, 7, 2);
      chk("ws_tex5_lit", 32'(m_tex[1][5]), 32'h2A);
   endtask

   task automatic test_fill();
      int busy;
      busy = 0;
      fill_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
      while (!wr_ready && busy < 1000) begin
         busy++;
         @(negedge clk);
      end
      chk("fill_busy_cycles", 32'(busy), 320);
      model_fill();
      pulse_swap();
      vsync_fall();
      m_rb = ~m_rb;
      chk("fill_rb", 32'(reading_buffer), 0);
      read_seq(0, COLS - 1, 1);
   endtask

   task automatic test_fill_swap();
      fill_req = 1'b1;
      swap_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
      swap_req = 1'b0;
      chk("fs_pending", 32'(swap_pending), 1);
      cycles(100);
      vsync_fall();
      chk("fs_no_swap_in_fill", 32'(reading_buffer), 0);
      chk("fs_pending_in_fill", 32'(swap_pending), 1);
      cycles(240);
      chk("fs_wait_ready", 32'(wr_ready), 0);
      chk("fs_still_front0", 32'(reading_buffer), 0);
      model_fill();
      vsync_fall();
      m_rb = ~m_rb;
      chk("fs_rb_toggled", 32'(reading_buffer), 1);
      chk("fs_pending_clear", 32'(swap_pending), 0);
      read_seq(0, COLS - 1, 7);
      read_seq(5, 7, 2);
   endtask

   task automatic test_error();
      chk("err_ready", 32'(wr_ready), 1);
      do_write(320, 6'h15, 16'hBEEF);
      chk("err_set", 32'(wr_error), 1);
      do_write(3, 6'h01, 16'h0042);
      cycles(3);
      chk("err_sticky", 32'(wr_error), 1);
      read_seq(318, 322, 2);
      read_seq(511, 511, 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      m_rb = 1'b0;
      chk("err_cleared", 32'(wr_error), 0);
   endtask

   task automatic test_reset_fill();
      fill_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
      cycles(50);
      pulse_swap();
      cycles(49);
      chk("rf_busy", 32'(wr_ready), 0);
      chk("rf_pending_before", 32'(swap_pending), 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("rf_ready", 32'(wr_ready), 1);
      chk("rf_rb", 32'(reading_buffer), 0);
      chk("rf_pending", 32'(swap_pending), 0);
      cycles(3);
      chk("rf_stays_idle", 32'(wr_ready), 1);
   endtask

   initial begin
      test_reset();
      test_write_swap();
      test_fill();
      test_fill_swap();
      test_error();
      test_reset_fill();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
